// File: rtl/mysystem_switch_ctrl.sv
// mysystem_switch_ctrl: Avalon-MM slave for the board slide switches.
// Input path: 2-flop synchronizer -> per-bit tick-based debounce ->
// edge capture -> maskable level interrupt.
// Optional build macro SWITCH_CTRL_BOTH_EDGES_EN: when defined, edgecap
// captures both rising and falling debounced transitions; otherwise rising only.
// Register map: 0 = deb (RO), 1 = reserved (reads 0), 2 = mask (RW),
// 3 = edgecap (write-1-to-clear, a same-cycle set wins).

module mysystem_switch_ctrl #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_mask;
    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic             w_tick;
    logic [WIDTH-1:0] w_deb_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_mask;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign readdata  = r_readdata;
    assign irq       = r_irq;
    assign w_tick    = (r_ps == PS_LAST);
    assign w_wr_mask = write && (address == 2'd2);
    assign w_clr     = (write && (address == 2'd3)) ? writedata[WIDTH-1:0] : {WIDTH{1'b0}};
    // Upper writedata bits are intentionally ignored when WIDTH < 32.
    assign w_unused  = ^writedata;

    // Two-flop synchronizer; r_s2 is the only consumer of the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= {WIDTH{1'b0}};
            r_s2 <= {WIDTH{1'b0}};
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // Free-running prescaler producing a one-cycle debounce tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ps <= {PS_W{1'b0}};
        end else if (w_tick) begin
            r_ps <= {PS_W{1'b0}};
        end else begin
            r_ps <= r_ps + PS_W'(1);
        end
    end

    // Per-bit debounce: agreement clears the count at once, disagreement counts ticks.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_deb_nxt[i] = r_deb[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (r_s2[i] == r_deb[i]) begin
                w_cnt_nxt[i] = {CNT_W{1'b0}};
            end else if (w_tick) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_deb_nxt[i] = r_s2[i];
                    w_cnt_nxt[i] = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_deb <= w_deb_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Edge detect on the debounced value, taken in the same cycle deb changes.
    always_comb begin
`ifdef SWITCH_CTRL_BOTH_EDGES_EN
        w_set = w_deb_nxt ^ r_deb;
`else
        w_set = w_deb_nxt & ~r_deb;
`endif
    end

    // Edge capture with write-1-to-clear; a simultaneous set keeps the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= {WIDTH{1'b0}};
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_set;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= {WIDTH{1'b0}};
        end else if (w_wr_mask) begin
            r_mask <= writedata[WIDTH-1:0];
        end else begin
            r_mask <= r_mask;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = 32'd0;
        case (address)
            2'd0:    w_rd_mux = 32'(r_deb);
            2'd1:    w_rd_mux = 32'd0;
            2'd2:    w_rd_mux = 32'(r_mask);
            2'd3:    w_rd_mux = 32'(r_edgecap);
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rd_mux;
            r_irq      <= |(r_edgecap & r_mask);
        end
    end

endmodule

// File: tb/tb_mysystem_switch_ctrl.sv
// Self-checking bench for mysystem_switch_ctrl (WIDTH=10, TICK_DIV=4, STABLE_TICKS=3).
// A behavioural reference model predicts readdata/irq after every clock edge and
// pushes the prediction into a scoreboard queue; a separate monitor pops and compares.
module tb_mysystem_switch_ctrl;

    localparam int W  = 10;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [1:0]    address   = 2'd0;
    logic          write     = 1'b0;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port   = '0;
    logic [31:0]   readdata;
    logic          irq;

    mysystem_switch_ctrl #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: pin history, debounced value, ticks seen while disagreeing.
    logic [W-1:0] m_pin1 = '0, m_pin2 = '0, m_deb = '0, m_edge = '0, m_mask = '0;
    int           m_cyc = 0;
    int           m_run [W];
    logic [31:0]  m_rd = 32'd0;
    logic         m_irq = 1'b0;

    // Model says bit 0 of deb will rise on the coming clock edge.
    function automatic bit rise0_next();
        return (m_pin2[0] == 1'b1) && (m_deb[0] == 1'b0) &&
               ((m_cyc % TD) == TD - 1) && (m_run[0] == ST - 1);
    endfunction

    // Advance one clock: predict from current inputs, wait for the edge, commit, queue it.
    task automatic step();
        logic [W-1:0] deb_n, edge_n, mask_n, set_v, clr_v;
        logic [31:0]  rd_n;
        logic         irq_n;
        int           run_n [W];
        bit           tick;
        if (reset) begin
            deb_n = '0; edge_n = '0; mask_n = '0; rd_n = 32'd0; irq_n = 1'b0;
            for (int i = 0; i < W; i++) run_n[i] = 0;
        end else begin
            tick  = ((m_cyc % TD) == TD - 1);
            deb_n = m_deb;
            for (int i = 0; i < W; i++) begin
                run_n[i] = m_run[i];
                if (m_pin2[i] == m_deb[i]) run_n[i] = 0;
                else if (tick) begin
                    if (m_run[i] + 1 >= ST) begin
                        deb_n[i] = m_pin2[i];
                        run_n[i] = 0;
                    end else run_n[i] = m_run[i] + 1;
                end
            end
`ifdef SWITCH_CTRL_BOTH_EDGES_EN
            set_v = deb_n ^ m_deb;
`else
            set_v = deb_n & ~m_deb;
`endif
            clr_v  = (write && address == 2'd3) ? writedata[W-1:0] : '0;
            edge_n = (m_edge & ~clr_v) | set_v;
            mask_n = (write && address == 2'd2) ? writedata[W-1:0] : m_mask;
            case (address)
                2'd0:    rd_n = {22'd0, m_deb};
                2'd2:    rd_n = {22'd0, m_mask};
                2'd3:    rd_n = {22'd0, m_edge};
                default: rd_n = 32'd0;
            endcase
            irq_n = |(m_edge & m_mask);
        end
        @(posedge clk);
        if (reset) begin
            m_pin1 = '0; m_pin2 = '0; m_cyc = 0;
        end else begin
            m_pin2 = m_pin1; m_pin1 = in_port; m_cyc = m_cyc + 1;
        end
        m_deb = deb_n; m_edge = edge_n; m_mask = mask_n; m_rd = rd_n; m_irq = irq_n;
        for (int i = 0; i < W; i++) m_run[i] = run_n[i];
        sb_q.push_back('{rd: rd_n, irq: irq_n});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; write = 1'b1; writedata = d;
        step();
        write = 1'b0;
    endtask

    // Directed check against a constant derived from the register-map rules.
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: one prediction per clock edge, compared 1 ns after it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (readdata !== e.rd || irq !== e.irq) begin
                    n_bad++;
                    $display("FAIL sb t=%0t addr=%0d: got rd=0x%08h irq=%b expected rd=0x%08h irq=%b",
                             $time, address, readdata, irq, e.rd, e.irq);
                end
            end
        end
    end

    initial begin : driver
        int  n;
        bit  found;
        for (int i = 0; i < W; i++) m_run[i] = 0;

        // Reset with all switches high, then requalify from zero.
        in_port = 10'h3FF; reset = 1'b1; address = 2'd0;
        idle(5);
        chk("reset_rd", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        idle(15);
        chk("deb_after_reset", readdata, 32'h3FF);
        address = 2'd3; step();
        chk("edge_after_reset", readdata, 32'h3FF);
        chk("irq_masked", {31'd0, irq}, 32'd0);

        // Drop all switches, clear edgecap, then raise bit 0 and measure latency.
        in_port = '0; idle(20);
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd0;
        in_port[0] = 1'b1;
        found = 1'b0; n = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (readdata[0]) begin found = 1'b1; n = k; end
        end
        chk("deb0_seen", {31'd0, found}, 32'd1);
        chk("deb0_window", {31'd0, (n >= 12 && n <= 15)}, 32'd1);

        // Glitches shorter than STABLE_TICKS ticks must not move deb[1].
        in_port[1] = 1'b1; step(); in_port[1] = 1'b0; idle(20);
        chk("glitch1", readdata, 32'h001);
        in_port[1] = 1'b1; idle(8); in_port[1] = 1'b0; idle(20);
        chk("glitch8", readdata, 32'h001);

        // Masked interrupt on bit 2, clear, then unmasked edge on bit 3.
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h004);
        address = 2'd3;
        in_port[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 25 && !found; k++) begin
            step();
            if (readdata[2]) found = 1'b1;
        end
        chk("edge2_seen", readdata, 32'h004);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h004);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        step();
        chk("irq_clear", {31'd0, irq}, 32'd0);
        in_port[3] = 1'b1; idle(20);
        chk("irq_unmasked", {31'd0, irq}, 32'd0);
        chk("edge3", readdata, 32'h008);

        // Set/clear collision on bit 0: clear write lands on the rising edge.
        in_port[0] = 1'b0; idle(20);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 25 && !found; k++) begin
            if (rise0_next()) begin
                wr(2'd3, 32'h001);
                found = 1'b1;
            end else step();
        end
        chk("collision_hit", {31'd0, found}, 32'd1);
        address = 2'd3; step();
        chk("collision_set_wins", {31'd0, readdata[0]}, 32'd1);

        // Register map behaviour.
        wr(2'd1, 32'hFFFF_FFFF); address = 2'd1; step();
        chk("addr1_reads0", readdata, 32'd0);
        wr(2'd2, 32'hFFFF_FFFF); address = 2'd2; step();
        chk("mask_rw", readdata, 32'h3FF);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); step();
            chk("upper_zero", {10'd0, readdata[31:10]}, 32'd0);
        end

        // Falling debounced edge on bit 5.
        in_port[5] = 1'b1; idle(20);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port[5] = 1'b0; idle(20);
        address = 2'd3; step();
`ifdef SWITCH_CTRL_BOTH_EDGES_EN
        chk("fall5", {31'd0, readdata[5]}, 32'd1);
`else
        chk("fall5", {31'd0, readdata[5]}, 32'd0);
`endif

        // Randomized traffic: slow pin changes, glitches, bus writes, rare resets.
        for (int k = 0; k < 4000; k++) begin
            address   = 2'($urandom_range(0, 3));
            write     = ($urandom_range(0, 7) == 0);
            writedata = $urandom;
            if ($urandom_range(0, 29) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            reset = ($urandom_range(0, 799) == 0);
            step();
        end
        reset = 1'b0; write = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
